// File: rtl/cassette_pkg.sv
// Shared cassette definitions: state encodings, framing bytes and default clock rate.
package cassette_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 3579545;

    localparam logic [7:0] LEADER_BYTE = 8'h55;
    localparam logic [7:0] SYNC_BYTE   = 8'h3C;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HUNT  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3
    } cas_state_e;

    // Newest bit enters at the MSB so the first bit received ends up as bit 0.
    function automatic logic [7:0] shift_lsb_first(input logic [7:0] win, input logic b);
        return {b, win[7:1]};
    endfunction

endpackage

// File: rtl/cas_period_meter.sv
// Synchronizes the cassette-out bit and measures rising-edge periods.
// CASREC_GLITCH_FILTER_EN adds a 4-sample stability filter after the synchronizer.
module cas_period_meter #(
    parameter int unsigned MIN_PER = 745,
    parameter int unsigned THRESH  = 1988,
    parameter int unsigned MAX_PER = 5965
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic edge_valid,
    output logic bit_val,
    output logic gap
);

    localparam int unsigned CW = $clog2(MAX_PER + 1);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_PER);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_PER);

    logic [1:0]    sync_q;
    logic          lvl;
    logic          lvl_prev_q;
    logic          rise;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            lvl_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= {sync_q[0], din};
            lvl_prev_q <= lvl;
            cnt_q      <= cnt_d;
        end
    end

`ifdef CASREC_GLITCH_FILTER_EN
    logic       filt_q;
    logic [1:0] stab_q;

    // The filtered level follows only after 4 consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= 1'b0;
            stab_q <= '0;
        end else if (sync_q[1] == filt_q) begin
            stab_q <= '0;
        end else if (stab_q == 2'd3) begin
            filt_q <= sync_q[1];
            stab_q <= '0;
        end else begin
            stab_q <= stab_q + 2'd1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[1];
`endif

    assign rise = lvl & ~lvl_prev_q;

    always_comb begin
        edge_valid = 1'b0;
        gap        = 1'b0;
        bit_val    = (cnt_q < THRESH_C);
        cnt_d      = cnt_q;
        if (rise && (cnt_q >= MIN_C)) begin
            cnt_d = CW'(1);
            if (cnt_q >= MAX_C) gap = 1'b1;
            else                edge_valid = 1'b1;
        end else begin
            // Glitch edges fall through here so the period keeps accumulating.
            if (cnt_q < MAX_C) cnt_d = cnt_q + CW'(1);
            if (cnt_q == MAX_C - CW'(1)) gap = 1'b1;
        end
    end

endmodule

// File: rtl/cassette_rec.sv
// Cassette recorder: decodes FSK cycles into leader-aligned bytes written to SDRAM.
// Optional CASREC_GLITCH_FILTER_EN is handled inside cas_period_meter.
module cassette_rec
    import cassette_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned THRESH  = CLK_HZ / 1800,
    parameter int unsigned MIN_PER = CLK_HZ / 4800,
    parameter int unsigned MAX_PER = CLK_HZ / 600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        record,
    input  logic        rewind,
    input  logic        din,
    output logic [24:0] sdram_addr,
    output logic [7:0]  sdram_data,
    output logic        sdram_wr,
    output logic [24:0] length,
    output logic [2:0]  status
);

    cas_state_e  state_q, state_d;
    logic [7:0]  win_q, win_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [24:0] addr_q, addr_d;
    logic [24:0] len_q, len_d;
    logic [7:0]  data_q, data_d;
    logic        rec_q, rew_q;
    logic        rec_edge, rew_edge;
    logic        edge_valid, bit_val, gap;
    logic [7:0]  shifted;

    cas_period_meter #(
        .MIN_PER (MIN_PER),
        .THRESH  (THRESH),
        .MAX_PER (MAX_PER)
    ) u_meter (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (din),
        .edge_valid (edge_valid),
        .bit_val    (bit_val),
        .gap        (gap)
    );

    assign rec_edge = record & ~rec_q;
    assign rew_edge = rewind ^ rew_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            win_q    <= '0;
            bitcnt_q <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            rec_q    <= 1'b0;
            rew_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            bitcnt_q <= bitcnt_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            data_q   <= data_d;
            rec_q    <= record;
            rew_q    <= rewind;
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        bitcnt_d = bitcnt_q;
        addr_d   = addr_q;
        len_d    = len_q;
        data_d   = data_q;
        shifted  = shift_lsb_first(win_q, bit_val);
        if (rew_edge) begin
            state_d  = IDLE;
            addr_d   = '0;
            len_d    = '0;
            win_d    = '0;
            bitcnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (rec_edge) begin
                        state_d  = HUNT;
                        win_d    = '0;
                        bitcnt_d = '0;
                    end
                end
                HUNT: begin
                    if (rec_edge) begin
                        state_d = IDLE;
                    end else if (gap) begin
                        win_d = '0;
                    end else if (edge_valid) begin
                        win_d = shifted;
                        if (shifted == LEADER_BYTE) begin
                            state_d  = WRITE;
                            data_d   = LEADER_BYTE;
                            bitcnt_d = '0;
                        end
                    end
                end
                DATA: begin
                    if (rec_edge) begin
                        state_d = IDLE;
                    end else if (gap) begin
                        state_d  = HUNT;
                        win_d    = '0;
                        bitcnt_d = '0;
                    end else if (edge_valid) begin
                        win_d    = shifted;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_d = WRITE;
                            data_d  = shifted;
                        end
                    end
                end
                WRITE: begin
                    // A stop request still lets the pending write account itself.
                    addr_d = addr_q + 25'd1;
                    if (len_q != '1) len_d = len_q + 25'd1;
                    state_d = rec_edge ? IDLE : DATA;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sdram_addr = addr_q;
    assign sdram_data = data_q;
    assign sdram_wr   = (state_q == WRITE);
    assign length     = len_q;
    assign status     = state_q;

endmodule

// File: tb/tb_cassette_rec.sv
// Bench for cassette_rec with a reduced clock rate so streams stay short.
module tb_cassette_rec;
    import cassette_pkg::*;

    localparam int unsigned TB_CLK = 180000;
    localparam int T1 = 75;   // 2400 Hz cycle, bit 1
    localparam int T0 = 150;  // 1200 Hz cycle, bit 0

    logic        clk = 1'b0;
    logic        reset_n, record, rewind, din;
    logic [24:0] sdram_addr, length;
    logic [7:0]  sdram_data;
    logic        sdram_wr;
    logic [2:0]  status;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  data;
        int          glitch;
        logic [24:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs_a[5];
    vec_t vecs_b[11];
    logic prev_wr = 1'b0;

    cassette_rec #(.CLK_HZ(TB_CLK)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .record     (record),
        .rewind     (rewind),
        .din        (din),
        .sdram_addr (sdram_addr),
        .sdram_data (sdram_data),
        .sdram_wr   (sdram_wr),
        .length     (length),
        .status     (status)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        int p;
        int h;
        p = b ? T1 : T0;
        h = p / 2;
        if (glitch) begin
            din = 1'b1; wait_cyc(10);
            din = 1'b0; wait_cyc(5);
            din = 1'b1; wait_cyc(h - 15);
        end else begin
            din = 1'b1; wait_cyc(h);
        end
        din = 1'b0;
        wait_cyc(p - h);
    endtask

    task automatic send_byte(input logic [7:0] v, input int glitch_idx);
        for (int i = 0; i < 8; i++) send_bit(v[i], i == glitch_idx);
    endtask

    // Trailing edge classifies the final cycle; the silence then forces a gap.
    task automatic end_stream();
        din = 1'b1; wait_cyc(T1 / 2);
        din = 1'b0; wait_cyc(400);
    endtask

    task automatic push_exp(input logic [24:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n && sdram_wr) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h required=no_write", sdram_addr, sdram_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (sdram_addr !== e.addr || sdram_data !== e.data || prev_wr) begin
                    failures++;
                    $display("FAIL write addr=%0h data=%0h back_to_back=%0b required addr=%0h data=%0h",
                             sdram_addr, sdram_data, prev_wr, e.addr, e.data);
                end
            end
        end
        prev_wr = sdram_wr;
    end

    initial begin
        logic [7:0] a_bytes [5];
        bit seen;
        a_bytes[0] = LEADER_BYTE; a_bytes[1] = 8'h12; a_bytes[2] = 8'h34;
        a_bytes[3] = 8'hAB;       a_bytes[4] = 8'hF0;
        for (int i = 0; i < 5; i++) begin
            vecs_a[i].data = a_bytes[i]; vecs_a[i].glitch = -1;
            vecs_a[i].exp_addr = 25'(i); vecs_a[i].exp_data = a_bytes[i];
        end
        for (int i = 0; i < 11; i++) begin
            vecs_b[i].data = (i == 10) ? SYNC_BYTE : LEADER_BYTE;
            vecs_b[i].glitch = (i == 3) ? 2 : -1;
            vecs_b[i].exp_addr = 25'(i);
            vecs_b[i].exp_data = vecs_b[i].data;
        end

        reset_n = 1'b0; record = 1'b0; rewind = 1'b0; din = 1'b0;
        wait_cyc(4);
        reset_n = 1'b1;
        wait_cyc(2);
        chk("reset_addr", 32'(sdram_addr), 0);
        chk("reset_data", 32'(sdram_data), 0);
        chk("reset_wr", 32'(sdram_wr), 0);
        chk("reset_length", 32'(length), 0);
        chk("reset_status", 32'(status), 0);

        // Misaligned start: two stray 1200 Hz bits ahead of the leader.
        record = 1'b1; wait_cyc(2);
        chk("a_status_hunt", 32'(status), 1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push_exp(vecs_a[i].exp_addr, vecs_a[i].exp_data);
            send_byte(vecs_a[i].data, vecs_a[i].glitch);
        end
        end_stream();
        chk("a_length", 32'(length), 5);
        chk("a_addr", 32'(sdram_addr), 5);
        chk("a_status_gap", 32'(status), 1);

        rewind = 1'b1; wait_cyc(3);
        chk("rewind_addr", 32'(sdram_addr), 0);
        chk("rewind_length", 32'(length), 0);
        chk("rewind_status", 32'(status), 0);
        rewind = 1'b0; wait_cyc(3);

        // Ten leaders plus sync byte, with a short glitch inside one 2400 Hz cycle.
        record = 1'b0; wait_cyc(2);
        record = 1'b1; wait_cyc(2);
        chk("b_status_hunt", 32'(status), 1);
        for (int i = 0; i < 11; i++) begin
            push_exp(vecs_b[i].exp_addr, vecs_b[i].exp_data);
            send_byte(vecs_b[i].data, vecs_b[i].glitch);
        end
        end_stream();
        chk("b_length", 32'(length), 11);
        chk("b_addr", 32'(sdram_addr), 11);

        // Silence after a partial byte drops it and returns to leader search.
        push_exp(25'd11, LEADER_BYTE);
        send_byte(LEADER_BYTE, -1);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        end_stream();
        wait_cyc(5600);
        chk("c_status_hunt", 32'(status), 1);
        chk("c_length_mid", 32'(length), 12);
        push_exp(25'd12, LEADER_BYTE);
        send_byte(LEADER_BYTE, -1);
        end_stream();
        chk("c_length", 32'(length), 13);
        chk("c_addr", 32'(sdram_addr), 13);

        // Stop keeps the address; simultaneous record and rewind favours rewind.
        record = 1'b0; wait_cyc(2);
        record = 1'b1; wait_cyc(2);
        chk("d_stop_status", 32'(status), 0);
        chk("d_stop_addr", 32'(sdram_addr), 13);
        record = 1'b0; wait_cyc(2);
        record = 1'b1; rewind = 1'b1; wait_cyc(2);
        chk("d_both_status", 32'(status), 0);
        chk("d_both_addr", 32'(sdram_addr), 0);
        chk("d_both_length", 32'(length), 0);
        rewind = 1'b0; record = 1'b0; wait_cyc(2);

        // Asynchronous reset landing in the WRITE cycle of the second byte.
        record = 1'b1; wait_cyc(2);
        chk("e_status_hunt", 32'(status), 1);
        push_exp(25'd0, LEADER_BYTE);
        push_exp(25'd1, SYNC_BYTE);
        fork
            begin
                send_byte(LEADER_BYTE, -1);
                send_byte(SYNC_BYTE, -1);
                end_stream();
            end
            begin
                seen = 1'b0;
                for (int n = 0; n < 4000 && !seen; n++) begin
                    @(negedge clk);
                    if (sdram_wr && sdram_addr == 25'd1) seen = 1'b1;
                end
                chk("e_write_seen", 32'(seen), 1);
                #2 reset_n = 1'b0;
                #1;
                chk("e_reset_wr", 32'(sdram_wr), 0);
                chk("e_reset_addr", 32'(sdram_addr), 0);
                chk("e_reset_data", 32'(sdram_data), 0);
                chk("e_reset_length", 32'(length), 0);
                chk("e_reset_status", 32'(status), 0);
                record = 1'b0;
            end
        join
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(10);
        chk("e_after_status", 32'(status), 0);
        chk("e_after_addr", 32'(sdram_addr), 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cassette_rec.md
Name: cassette_rec

Overview:
- Recording counterpart to the cassette playback path.
- Samples the MC-10 cassette-out bit and measures the period between rising edges. Each cycle is classified as a 1200 Hz cycle (bit 0) or a 2400 Hz cycle (bit 1).
- Bits are assembled LSB-first into bytes, aligned on the 0x55 leader.
- Each byte is written sequentially into SDRAM from address 0, so the image can be replayed later by the playback block.

Parameters:
- CLK_HZ, 3579545: clk frequency in Hz.
- THRESH, CLK_HZ/1800: period in cycles. A period below THRESH is bit 1; a period at or above it is bit 0.
- MIN_PER, CLK_HZ/4800: periods shorter than this are glitches and are ignored.
- MAX_PER, CLK_HZ/600: periods at or above this, or silence of this length, count as a block gap.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- record  in  1  level; each rising edge toggles IDLE <-> recording
- rewind  in  1  any edge resets address, length and state
- din  in  1  cassette-out bit from the CPU; asynchronous
- sdram_addr  out  25  write address
- sdram_data  out  8  write byte
- sdram_wr  out  1  one-cycle write strobe
- length  out  25  number of bytes written since rewind
- status  out  3  current state encoding

Behaviour:
- Reset: sdram_addr=0, sdram_data=0, sdram_wr=0, length=0, status=IDLE. Internal period counter, bit shift register and bit count are all cleared.
- Reset is asynchronous to all flops. Reset mid-write drops the byte.
- din passes through a two-flop synchronizer. A rising edge is recognized 3 clk after the din edge.
- Period counter:
  - Counts up every clk and saturates at MAX_PER.
  - On a recognized rising edge with period < MIN_PER: the edge is ignored and the counter keeps running.
  - Otherwise the period is classified and the counter restarts at 1.
- States:
  - IDLE(0): edges ignored. A record rising edge goes to HUNT.
  - HUNT(1):
    - Each classified bit shifts into an 8-bit window, MSB-in, giving LSB-first byte order.
    - When window==0x55: go to WRITE with byte 0x55, bitcnt=0. This establishes byte alignment.
  - DATA(2): shift each bit in. On the 8th bit, go to WRITE with the assembled byte.
  - WRITE(3):
    - Lasts exactly 1 cycle: sdram_wr=1, with sdram_data and sdram_addr stable.
    - On the following cycle: sdram_addr+1, length+1, state DATA.
- Gap handling, in HUNT or DATA: a period >= MAX_PER, or the counter saturating with no edge, goes to HUNT. The partial byte is discarded and the window cleared.
- A record rising edge in any non-IDLE state goes to IDLE. If this happens in WRITE, the write completes first, then IDLE.
- Rewind edge:
  - Takes priority over record in the same cycle.
  - Sets sdram_addr=0, length=0, state=IDLE, window cleared.
  - A rewind arriving in WRITE aborts the increment.
- Address wrap: 25-bit wraps to 0. length saturates at 2^25-1.
- No write overrun is possible: the minimum byte time of 8*MIN_PER cycles is much greater than the 1-cycle WRITE.

Optional Feature:
- Macro: CASREC_GLITCH_FILTER_EN.
- Defined:
  - A 4-cycle stability filter follows the synchronizer. The filtered din changes only after 4 consecutive equal samples.
  - Edge recognition latency becomes 7 clk.
  - Pulses shorter than 4 clk never produce edges.
- Undefined: synchronizer only, latency 3 clk.

Decomposition:
- Package cassette_pkg holds:
  - state encodings IDLE/HUNT/DATA/WRITE;
  - constants LEADER_BYTE=8'h55 and SYNC_BYTE=8'h3C, also shared with the playback EOF detection;
  - the default CLK_HZ.
- Sub-module cas_period_meter contains the synchronizer, optional filter, edge detect and saturating counter. Its outputs are edge_valid, bit_val and gap.

Test Plan:
- record edge, then ten 0x55 bytes followed by 0x3C as 2400/1200 Hz square cycles -> eleven writes at addr 0..10 with data 0x55 x10, 0x3C; length=11.
- Two leading 1200 Hz bits before the leader (misalignment) -> first write is still 0x55 at addr 0; the stray bits are never written.
- Silence of 6000 cycles after 3 data bits -> state HUNT, no write; the next 0x55 is written at the next addr.
- A 300-cycle pulse inside a 2400 Hz cycle -> ignored; byte value unchanged. With CASREC_GLITCH_FILTER_EN, a 3-cycle pulse produces no edge at all.
- rewind edge after 5 bytes -> sdram_addr=0, length=0, status=0. If record and rewind rise in the same cycle, the rewind wins.
- reset_n low during WRITE -> sdram_wr=0 immediately and all outputs at reset values.
